e15_prog_loader: RTL and testbench
==================================

// Module: e15_prog_loader
// PURPOSE
//  Writer side of the E15 program store: fills the 16x12 instruction memory the
//  core fetches from, replacing the hard-coded initial-block program.
//  Takes 4-bit nibbles over a valid/ready link, packs three nibbles into one
//  12-bit instruction {opcode,src,dst,imm}, and issues one write per word.
//  Holds the core (cpu_hold) until a full image is loaded.
// PARAMETERS
//  DEPTH       16  number of instruction words per image (1..16)
//  START_ADDR  0   first write address; addresses wrap modulo 16
// PORTS
//  clk       in   1   system clock, all logic on rising edge
//  rst       in   1   synchronous active-high reset
//  start     in   1   one-cycle pulse: begin loading a new image
//  in_nib    in   4   payload nibble
//  in_valid  in   1   in_nib valid
//  in_ready  out  1   loader accepts a nibble this cycle
//  wr_en     out  1   one-cycle write strobe to instruction memory
//  wr_addr   out  4   write address
//  wr_data   out  12  instruction word {opcode[11:8],src[7:6],dst[5:4],imm[3:0]}
//  cpu_hold  out  1   1 = core held (pc frozen at 0); 0 = core may run
//  done      out  1   sticky: image loaded successfully
//  err       out  1   sticky: load failed (checksum build only)
// BEHAVIOUR
//  Reset values: in_ready=0 wr_en=0 wr_addr=START_ADDR wr_data=0 cpu_hold=1
//   done=0 err=0; state=IDLE, nibble count=0, word count=0.
//  Handshake: a nibble is taken on any edge with in_valid & in_ready; in_nib
//   must stay stable while in_valid=1 & in_ready=0. in_ready is a registered
//   state decode: 1 only in LOAD or CHECK.
//  Packing: MSB nibble first; 1st nibble -> [11:8], 2nd -> [7:4], 3rd -> [3:0].
//  Write latency: wr_en=1 for exactly one cycle, on the cycle after the 3rd
//   nibble is accepted; wr_addr/wr_data are valid with it and hold afterwards.
//  Address: starts at START_ADDR; increments by 1 after each write (4-bit, so
//   15 -> 0 wraps silently).
//  States:
//   IDLE : cpu_hold=1. start -> LOAD (clear counters, done, err; wr_addr=START_ADDR).
//   LOAD : accept nibbles; after word DEPTH is written -> CHECK if
//          E15_LOAD_CHECKSUM_EN, else -> DONE.
//   CHECK: accept exactly one nibble; match -> DONE, mismatch -> ERR.
//   DONE : done=1, cpu_hold=0, in_ready=0. start -> LOAD (cpu_hold=1 next cycle).
//   ERR  : err=1, cpu_hold=1, in_ready=0. start -> LOAD.
//  Boundaries:
//   start while in LOAD/CHECK is ignored; no restart mid-image.
//   start and in_valid on the same edge in IDLE: start wins, nibble not taken.
//   Nibbles offered in IDLE/DONE/ERR: not accepted (in_ready=0), no effect.
//   rst mid-load: back to IDLE, partial word discarded, no wr_en. Memory
//    contents already written are left alone.
//   in_valid gaps of any length inside a word are allowed; the counters hold.
// CONFIGURATION
//  E15_LOAD_CHECKSUM_EN defined: after DEPTH words, one extra nibble must equal
//   the XOR of all 3*DEPTH payload nibbles; mismatch -> ERR and cpu_hold stays 1.
//  Not defined: no CHECK state; err is tied 0; DONE follows the last write.
// TESTING
//  1. rst, then start, 48 nibbles (DEPTH=16) forming words 0x910..0x91F ->
//     16 wr_en pulses at addr 0..15 with matching data; done=1, cpu_hold=0.
//  2. Nibbles 9,4,3 with in_valid gaps of 0/2/5 cycles -> one write
//     0x943@addr0, wr_en exactly one cycle after the 3rd accept.
//  3. START_ADDR=14, DEPTH=4, words A,B,C,D -> writes to addr 14,15,0,1.
//  4. rst after 5 nibbles -> no 2nd write, state IDLE, cpu_hold=1, done=0;
//     a new start then writes the first word to START_ADDR.
//  5. start pulsed during LOAD and nibbles offered in DONE -> ignored; write
//     count and addresses unchanged.
//  6. (CHECKSUM_EN) DEPTH=1, nibbles 9,1,5, check=D -> done=1; check=0 ->
//     err=1, cpu_hold=1; a following start clears err.

Source files
------------

// File: rtl/e15_prog_loader.sv
// rtl/e15_prog_loader.sv - E15 instruction-memory loader: packs nibbles into 12-bit words and holds the core until loaded.
// Optional trailing XOR checksum nibble enabled by defining E15_LOAD_CHECKSUM_EN.
module e15_prog_loader #(
    parameter int         DEPTH      = 16,
    parameter logic [3:0] START_ADDR = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  in_nib,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        wr_en,
    output logic [3:0]  wr_addr,
    output logic [11:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  nib_cnt;
    logic [4:0]  word_cnt;
    logic [7:0]  part;
    logic [3:0]  next_addr;
    logic        take;
    logic        last_nib;
    logic        last_word;
    logic        begin_load;

`ifdef E15_LOAD_CHECKSUM_EN
    logic [3:0]  csum;
`endif

    assign take       = in_valid & in_ready;
    assign last_nib   = (nib_cnt == 2'd2);
    assign last_word  = (word_cnt == 5'(DEPTH - 1));
    // start is honoured only between images; mid-image pulses fall through
    assign begin_load = start && (state == S_IDLE || state == S_DONE || state == S_ERR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (take && last_nib && last_word) begin
`ifdef E15_LOAD_CHECKSUM_EN
                    state_next = S_CHECK;
`else
                    state_next = S_DONE;
`endif
                end
            end
            S_CHECK: begin
`ifdef E15_LOAD_CHECKSUM_EN
                if (take) begin
                    state_next = (in_nib == csum) ? S_DONE : S_ERR;
                end
`else
                state_next = S_IDLE;
`endif
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == S_LOAD) || (state == S_CHECK);
        cpu_hold = (state != S_DONE);
        done     = (state == S_DONE);
`ifdef E15_LOAD_CHECKSUM_EN
        err      = (state == S_ERR);
`else
        err      = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nib_cnt   <= 2'd0;
            word_cnt  <= 5'd0;
            part      <= 8'd0;
            next_addr <= START_ADDR;
            wr_en     <= 1'b0;
            wr_addr   <= START_ADDR;
            wr_data   <= 12'd0;
`ifdef E15_LOAD_CHECKSUM_EN
            csum      <= 4'd0;
`endif
        end else begin
            wr_en <= 1'b0;
            if (begin_load) begin
                nib_cnt   <= 2'd0;
                word_cnt  <= 5'd0;
                part      <= 8'd0;
                next_addr <= START_ADDR;
                wr_addr   <= START_ADDR;
`ifdef E15_LOAD_CHECKSUM_EN
                csum      <= 4'd0;
`endif
            end else if (state == S_LOAD && take) begin
`ifdef E15_LOAD_CHECKSUM_EN
                csum <= csum ^ in_nib;
`endif
                if (last_nib) begin
                    wr_en     <= 1'b1;
                    wr_data   <= {part, in_nib};
                    wr_addr   <= next_addr;
                    next_addr <= next_addr + 4'd1;
                    nib_cnt   <= 2'd0;
                    word_cnt  <= word_cnt + 5'd1;
                end else begin
                    part    <= {part[3:0], in_nib};
                    nib_cnt <= nib_cnt + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_e15_prog_loader.sv
// tb/tb_e15_prog_loader.sv - directed self-checking bench for e15_prog_loader.
module tb_e15_prog_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_start, a_valid, a_ready, a_wr_en, a_hold, a_done, a_err;
    logic [3:0]  a_nib, a_wr_addr;
    logic [11:0] a_wr_data;
    logic        b_start, b_valid, b_ready, b_wr_en, b_hold, b_done, b_err;
    logic [3:0]  b_nib, b_wr_addr;
    logic [11:0] b_wr_data;

    int checks = 0;
    int errors = 0;

    int          a_wcnt = 0;
    logic [3:0]  a_waddr [0:255];
    logic [11:0] a_wdata [0:255];
    int          b_wcnt = 0;
    logic [3:0]  b_waddr [0:255];
    logic [11:0] b_wdata [0:255];

    e15_prog_loader dut_a (
        .clk(clk), .rst(rst), .start(a_start), .in_nib(a_nib), .in_valid(a_valid),
        .in_ready(a_ready), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .cpu_hold(a_hold), .done(a_done), .err(a_err)
    );

    e15_prog_loader #(.DEPTH(4), .START_ADDR(4'd14)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .in_nib(b_nib), .in_valid(b_valid),
        .in_ready(b_ready), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .cpu_hold(b_hold), .done(b_done), .err(b_err)
    );

`ifdef E15_LOAD_CHECKSUM_EN
    logic        c_start, c_valid, c_ready, c_wr_en, c_hold, c_done, c_err;
    logic [3:0]  c_nib, c_wr_addr;
    logic [11:0] c_wr_data;

    e15_prog_loader #(.DEPTH(1), .START_ADDR(4'd0)) dut_c (
        .clk(clk), .rst(rst), .start(c_start), .in_nib(c_nib), .in_valid(c_valid),
        .in_ready(c_ready), .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
        .cpu_hold(c_hold), .done(c_done), .err(c_err)
    );
`endif

    always @(posedge clk) begin
        #1;
        if (a_wr_en === 1'b1) begin
            a_waddr[a_wcnt % 256] = a_wr_addr;
            a_wdata[a_wcnt % 256] = a_wr_data;
            a_wcnt++;
        end
        if (b_wr_en === 1'b1) begin
            b_waddr[b_wcnt % 256] = b_wr_addr;
            b_wdata[b_wcnt % 256] = b_wr_data;
            b_wcnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int w);
        case (w)
            0: rdy = a_ready;
            1: rdy = b_ready;
`ifdef E15_LOAD_CHECKSUM_EN
            2: rdy = c_ready;
`endif
            default: rdy = 1'b0;
        endcase
    endfunction

    task automatic set_in(input int w, input logic v, input logic [3:0] n);
        case (w)
            0: begin a_valid = v; a_nib = n; end
            1: begin b_valid = v; b_nib = n; end
`ifdef E15_LOAD_CHECKSUM_EN
            2: begin c_valid = v; c_nib = n; end
`endif
            default: ;
        endcase
    endtask

    task automatic set_start(input int w, input logic s);
        case (w)
            0: a_start = s;
            1: b_start = s;
`ifdef E15_LOAD_CHECKSUM_EN
            2: c_start = s;
`endif
            default: ;
        endcase
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input int w, input logic [3:0] n, input int gap);
        int t;
        repeat (gap) @(negedge clk);
        set_in(w, 1'b1, n);
        t = 0;
        while (rdy(w) !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("handshake_ready", {31'd0, rdy(w)}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        set_in(w, 1'b0, n);
    endtask

    task automatic pulse_start(input int w);
        set_start(w, 1'b1);
        @(negedge clk);
        set_start(w, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 1'b1;
        a_start = 0; a_valid = 0; a_nib = 0;
        b_start = 0; b_valid = 0; b_nib = 0;
`ifdef E15_LOAD_CHECKSUM_EN
        c_start = 0; c_valid = 0; c_nib = 0;
`endif
        @(negedge clk);
        do_reset();

        chk("rst_in_ready", a_ready, 0);
        chk("rst_wr_en", a_wr_en, 0);
        chk("rst_wr_addr", a_wr_addr, 0);
        chk("rst_wr_data", a_wr_data, 0);
        chk("rst_cpu_hold", a_hold, 1);
        chk("rst_done", a_done, 0);
        chk("rst_err", a_err, 0);
        chk("rst_b_wr_addr", b_wr_addr, 14);

        // full 16-word image 0x910..0x91F
        base = a_wcnt;
        pulse_start(0);
        chk("load_hold", a_hold, 1);
        for (int i = 0; i < 16; i++) begin
            send(0, 4'h9, 0);
            send(0, 4'h1, 0);
            send(0, 4'(i), 0);
        end
        @(negedge clk);
        chk("img_write_count", a_wcnt - base, 16);
        for (int i = 0; i < 16; i++) begin
            chk("img_addr", a_waddr[(base + i) % 256], i);
            chk("img_data", a_wdata[(base + i) % 256], 32'h910 + i);
        end
        chk("img_done", a_done, 1);
        chk("img_cpu_hold", a_hold, 0);
        chk("img_in_ready", a_ready, 0);

        // nibbles offered in DONE are ignored
        base = a_wcnt;
        a_valid = 1'b1; a_nib = 4'h5;
        repeat (3) @(negedge clk);
        chk("done_in_ready", a_ready, 0);
        a_valid = 1'b0;
        chk("done_no_write", a_wcnt - base, 0);
        chk("done_sticky", a_done, 1);

        pulse_start(0);
        chk("restart_hold", a_hold, 1);
        chk("restart_done", a_done, 0);

        // gapped nibbles 9,4,3 -> 0x943 at addr 0
        base = a_wcnt;
        send(0, 4'h9, 0);
        send(0, 4'h4, 2);
        chk("gap_no_early_write", a_wcnt - base, 0);
        send(0, 4'h3, 5);
        chk("gap_wr_en_latency", a_wr_en, 1);
        chk("gap_write_count", a_wcnt - base, 1);
        chk("gap_addr", a_wr_addr, 0);
        chk("gap_data", a_wr_data, 12'h943);
        @(negedge clk);
        chk("gap_wr_en_one_cycle", a_wr_en, 0);
        chk("gap_data_hold", a_wr_data, 12'h943);

        // start mid-load is ignored
        send(0, 4'h5, 0);
        pulse_start(0);
        send(0, 4'h6, 0);
        send(0, 4'h7, 0);
        chk("midstart_count", a_wcnt - base, 2);
        chk("midstart_addr", a_waddr[(base + 1) % 256], 1);
        chk("midstart_data", a_wdata[(base + 1) % 256], 12'h567);

        // reset after 5 nibbles
        do_reset();
        base = a_wcnt;
        pulse_start(0);
        send(0, 4'h1, 0);
        send(0, 4'h2, 0);
        send(0, 4'h3, 0);
        send(0, 4'h4, 0);
        send(0, 4'h5, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_mid_count", a_wcnt - base, 1);
        chk("rst_mid_ready", a_ready, 0);
        chk("rst_mid_hold", a_hold, 1);
        chk("rst_mid_done", a_done, 0);

        // start and in_valid on the same edge: nibble taken only after
        a_start = 1'b1; a_valid = 1'b1; a_nib = 4'h7;
        @(negedge clk);
        a_start = 1'b0;
        chk("start_wins_ready", a_ready, 1);
        @(negedge clk);
        a_valid = 1'b0;
        send(0, 4'h8, 0);
        send(0, 4'h9, 0);
        chk("restart_count", a_wcnt - base, 2);
        chk("restart_addr", a_wr_addr, 0);
        chk("restart_data", a_wr_data, 12'h789);

        // START_ADDR=14, DEPTH=4: addresses wrap 14,15,0,1
        base = b_wcnt;
        pulse_start(1);
        for (int j = 0; j < 4; j++) begin
            send(1, 4'(10 + j), 0);
            send(1, 4'(10 + j), 0);
            send(1, 4'(10 + j), 0);
        end
        @(negedge clk);
        chk("wrap_count", b_wcnt - base, 4);
        chk("wrap_addr0", b_waddr[(base + 0) % 256], 14);
        chk("wrap_addr1", b_waddr[(base + 1) % 256], 15);
        chk("wrap_addr2", b_waddr[(base + 2) % 256], 0);
        chk("wrap_addr3", b_waddr[(base + 3) % 256], 1);
        chk("wrap_data0", b_wdata[(base + 0) % 256], 12'hAAA);
        chk("wrap_data3", b_wdata[(base + 3) % 256], 12'hDDD);
        chk("wrap_done", b_done, 1);
        chk("wrap_hold", b_hold, 0);

`ifdef E15_LOAD_CHECKSUM_EN
        // checksum of 9,1,5 is D
        pulse_start(2);
        send(2, 4'h9, 0);
        send(2, 4'h1, 0);
        send(2, 4'h5, 0);
        chk("csum_pending_done", c_done, 0);
        send(2, 4'hD, 0);
        chk("csum_ok_done", c_done, 1);
        chk("csum_ok_err", c_err, 0);
        chk("csum_ok_hold", c_hold, 0);
        pulse_start(2);
        send(2, 4'h9, 0);
        send(2, 4'h1, 0);
        send(2, 4'h5, 0);
        send(2, 4'h0, 0);
        chk("csum_bad_err", c_err, 1);
        chk("csum_bad_hold", c_hold, 1);
        chk("csum_bad_done", c_done, 0);
        pulse_start(2);
        chk("csum_clear_err", c_err, 0);
`else
        chk("err_tied_a", a_err, 0);
        chk("err_tied_b", b_err, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
